// File: rtl/irq_ctrl.sv
// Peripheral interrupt controller: per-source synchroniser, edge/level pending
// register with enable mask, registered irq vector and a single-cycle-ready bus slave.
module irq_ctrl #(
  parameter int unsigned IRQ_CH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] src,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [2:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  output logic [IRQ_CH-1:0] irq
);

  localparam int unsigned IDX_W = (IRQ_CH > 1) ? $clog2(IRQ_CH) : 1;

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MODE    = 3'd2,
    REG_RAW     = 3'd3,
    REG_HIGHEST = 3'd4,
    REG_SET     = 3'd5
  } reg_addr_e;

  logic [IRQ_CH-1:0] s1_q, s2_q, s3_q;
  logic [IRQ_CH-1:0] s1_d, s2_d, s3_d;
  logic [IRQ_CH-1:0] pend_q, pend_d;
  logic [IRQ_CH-1:0] en_q, en_d;
  logic [IRQ_CH-1:0] mode_q, mode_d;
  logic [IRQ_CH-1:0] irq_q, irq_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rdy_n_q, rdy_n_d;

  logic              access, wr_en, rd_en;
  logic [IRQ_CH-1:0] wr_bits, rise, active, w1c, sw_set;
  logic              found;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_val;

  always_comb begin
    access  = ~cs_ & ~as_;
    wr_en   = access & ~rw;
    rd_en   = access & rw;
    wr_bits = wr_data[IRQ_CH-1:0];

    s1_d = src;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;

    active = pend_q & en_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < IRQ_CH; i++) begin
      if (active[i] && !found) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
      end
    end

    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    sw_set = '0;
    if (wr_en) begin
      case (reg_addr_e'(addr))
        REG_PENDING: w1c    = wr_bits;
        REG_ENABLE:  en_d   = wr_bits;
        REG_MODE:    mode_d = wr_bits;
        REG_SET:     sw_set = wr_bits;
        default:     ;
      endcase
    end

    // Set wins over clear so a rise coinciding with W1C is never lost.
    pend_d = (mode_q & (rise | sw_set | (pend_q & ~w1c))) | (~mode_q & s2_q);
    irq_d  = active;

    rd_val = '0;
    case (reg_addr_e'(addr))
      REG_PENDING: rd_val[IRQ_CH-1:0] = pend_q;
      REG_ENABLE:  rd_val[IRQ_CH-1:0] = en_q;
      REG_MODE:    rd_val[IRQ_CH-1:0] = mode_q;
      REG_RAW:     rd_val[IRQ_CH-1:0] = s2_q;
      REG_HIGHEST: begin
        rd_val[31]        = found;
        rd_val[IDX_W-1:0] = idx;
      end
      default:     ;
    endcase

    rd_data_d = rd_en ? rd_val : '0;
    rdy_n_d   = ~access;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      mode_q    <= '1;
      irq_q     <= '0;
      rd_data_q <= '0;
      rdy_n_q   <= 1'b1;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      rdy_n_q   <= rdy_n_d;
    end
  end

  generate
    if (IRQ_CH < 32) begin : g_unused_hi
      logic unused_wr_hi;
      assign unused_wr_hi = ^wr_data[31:IRQ_CH];
    end
  endgenerate

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_n_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register map, edge/level detection, W1C/SET,
// bus handshake and asynchronous reset.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  src;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [7:0]  irq;

  int unsigned errors = 0;
  int unsigned checks = 0;

  irq_ctrl #(.IRQ_CH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic pulse_ok);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk);
    d        = rd_data;
    pulse_ok = (rdy_ === 1'b0);
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    pulse_ok = pulse_ok && (rdy_ === 1'b1) && (rd_data === 32'h0);
  endtask

  // Called at a negedge; returns at the negedge right after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] exp_rd [8];
    logic [31:0] d;
    logic        ok;
    exp_rd = '{32'h0, 32'h0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL reset_irq: got %h expected %h", irq, 8'h00); end
    checks++; if (rdy_ !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy_); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d, ok);
      checks++; if (d !== exp_rd[i]) begin errors++; $display("FAIL reset_read[%0d]: got %h expected %h", i, d, exp_rd[i]); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reset_rdy_pulse[%0d]: got %b expected 1", i, ok); end
    end
  endtask

  task automatic test_edge;
    logic [31:0] d;
    logic        ok;
    bus_write(3'd1, 32'h05);
    bus_write(3'd2, 32'hFF);
    src = 8'h04;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL edge_irq_e2: got %h expected %h", irq, 8'h00); end
    src = 8'h00;
    @(negedge clk);
    checks++; if (irq !== 8'h04) begin errors++; $display("FAIL edge_irq_e3: got %h expected %h", irq, 8'h04); end
    bus_read(3'd0, d, ok);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL edge_pending: got %h expected %h", d, 32'h04); end
    bus_read(3'd4, d, ok);
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL edge_highest: got %h expected %h", d, 32'h8000_0002); end
    repeat (3) @(negedge clk);
    checks++; if (irq !== 8'h04) begin errors++; $display("FAIL edge_irq_held: got %h expected %h", irq, 8'h04); end
    bus_write(3'd0, 32'h04);
    checks++; if (irq !== 8'h04) begin errors++; $display("FAIL edge_w1c_same_cycle: got %h expected %h", irq, 8'h04); end
    @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL edge_w1c_next: got %h expected %h", irq, 8'h00); end
  endtask

  task automatic test_rise_w1c;
    logic [31:0] d;
    logic        ok;
    bus_write(3'd5, 32'h04);
    src = 8'h04;
    repeat (2) @(negedge clk);
    bus_write(3'd0, 32'h04);
    checks++; if (irq !== 8'h04) begin errors++; $display("FAIL rise_w1c_irq0: got %h expected %h", irq, 8'h04); end
    @(negedge clk);
    checks++; if (irq !== 8'h04) begin errors++; $display("FAIL rise_w1c_irq1: got %h expected %h", irq, 8'h04); end
    bus_read(3'd0, d, ok);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL rise_w1c_pending: got %h expected %h", d, 32'h04); end
    src = 8'h00;
    repeat (3) @(negedge clk);
    bus_write(3'd0, 32'hFF);
    @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL rise_w1c_cleanup: got %h expected %h", irq, 8'h00); end
  endtask

  task automatic test_level;
    logic [7:0] exp_irq;
    bus_write(3'd2, 32'h00);
    bus_write(3'd1, 32'h01);
    @(negedge clk);
    src = 8'h01;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      exp_irq = (k >= 3 && k <= 12) ? 8'h01 : 8'h00;
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL level_irq[k=%0d]: got %h expected %h", k, irq, exp_irq); end
      if (k == 9) src = 8'h00;
      if (k == 5) begin
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 3'd0; wr_data = 32'h01;
      end
      if (k == 6) begin
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
        checks++; if (rdy_ !== 1'b0) begin errors++; $display("FAIL level_w1c_ack: got %b expected 0", rdy_); end
      end
    end
  endtask

  task automatic test_set;
    logic [31:0] d;
    logic        ok;
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'h00);
    bus_write(3'd5, 32'h81);
    @(negedge clk);
    bus_read(3'd0, d, ok);
    checks++; if (d !== 32'h81) begin errors++; $display("FAIL set_pending: got %h expected %h", d, 32'h81); end
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL set_irq_masked: got %h expected %h", irq, 8'h00); end
    bus_write(3'd1, 32'hFFFF_FFFF);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL set_irq_w: got %h expected %h", irq, 8'h00); end
    @(negedge clk);
    checks++; if (irq !== 8'h81) begin errors++; $display("FAIL set_irq_w1: got %h expected %h", irq, 8'h81); end
    bus_read(3'd4, d, ok);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL set_highest: got %h expected %h", d, 32'h8000_0000); end
    bus_write(3'd7, 32'h0);
    bus_write(3'd6, 32'h0);
    bus_read(3'd1, d, ok);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL set_enable_width: got %h expected %h", d, 32'h0000_00FF); end
  endtask

  task automatic test_back_to_back;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 3'd0;
    @(negedge clk);
    checks++; if (rdy_ !== 1'b0) begin errors++; $display("FAIL b2b_rdy0: got %b expected 0", rdy_); end
    checks++; if (rd_data !== 32'h81) begin errors++; $display("FAIL b2b_data0: got %h expected %h", rd_data, 32'h81); end
    addr = 3'd1;
    @(negedge clk);
    checks++; if (rdy_ !== 1'b0) begin errors++; $display("FAIL b2b_rdy1: got %b expected 0", rdy_); end
    checks++; if (rd_data !== 32'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected %h", rd_data, 32'hFF); end
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    checks++; if (rdy_ !== 1'b1) begin errors++; $display("FAIL b2b_rdy_idle: got %b expected 1", rdy_); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL b2b_data_idle: got %h expected 0", rd_data); end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    logic        ok;
    src = 8'hFF;
    repeat (5) @(negedge clk);
    checks++; if (irq !== 8'hFF) begin errors++; $display("FAIL ar_irq_all: got %h expected %h", irq, 8'hFF); end
    bus_read(3'd3, d, ok);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL ar_raw: got %h expected %h", d, 32'hFF); end
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 3'd0;
    #2 reset = 1'b1;
    #1;
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL ar_irq_immediate: got %h expected %h", irq, 8'h00); end
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    reset = 1'b0;
    checks++; if (rdy_ !== 1'b1) begin errors++; $display("FAIL ar_rdy_in_reset: got %b expected 1", rdy_); end
    @(negedge clk);
    checks++; if (rdy_ !== 1'b1) begin errors++; $display("FAIL ar_no_ack: got %b expected 1", rdy_); end
    repeat (4) @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL ar_irq_after: got %h expected %h", irq, 8'h00); end
    bus_write(3'd0, 32'hFF);
    bus_write(3'd1, 32'hFF);
    repeat (3) @(negedge clk);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL ar_no_rise_steady: got %h expected %h", irq, 8'h00); end
    src = 8'h00;
    repeat (3) @(negedge clk);
    src = 8'hFF;
    repeat (4) @(negedge clk);
    checks++; if (irq !== 8'hFF) begin errors++; $display("FAIL ar_rise_after_toggle: got %h expected %h", irq, 8'hFF); end
  endtask

  initial begin
    reset = 1'b1; src = 8'h00; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    addr = 3'd0; wr_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_edge();
    test_rise_w1c();
    test_level();
    test_set();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
